// File: rtl/divisible_by_n_stream.sv
// rtl/divisible_by_n_stream.sv - streaming divisibility checker, W bits per accepted digit
// Keeps the running value mod DIVISOR, plus a place weight for LSB-first order and a saturating bit count.

module divisible_by_n_stream #(
  parameter int DIVISOR   = 3,
  parameter int W         = 1,
  parameter bit MSB_FIRST = 1'b1,
  parameter int LEN_W     = 16,
  localparam int RW       = (DIVISOR <= 2) ? 1 : $clog2(DIVISOR)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic             clear_i,
  input  logic [W-1:0]     x_i,
  output logic             div_o,
  output logic [RW-1:0]    rem_o,
  output logic [LEN_W-1:0] len_o
);

  localparam logic [RW:0]      N_EXT    = (RW + 1)'(DIVISOR);
  localparam logic [RW-1:0]    W_INIT   = (DIVISOR == 1) ? '0 : RW'(1);
  localparam logic [LEN_W:0]   W_STEP   = (LEN_W + 1)'(W);
  localparam logic [LEN_W-1:0] LEN_MAX  = '1;

  logic [RW-1:0]    r_rem;
  logic [RW-1:0]    r_weight;
  logic [LEN_W-1:0] r_len;
  logic             r_div;

  logic [RW:0]      w_rem_acc;
  logic [RW:0]      w_weight_acc;
  logic [LEN_W:0]   w_len_sum;
  logic [LEN_W-1:0] w_len_nxt;

  // One reduction step per bit keeps every intermediate below 2*DIVISOR.
  always_comb begin
    w_rem_acc    = clear_i ? '0 : {1'b0, r_rem};
    w_weight_acc = clear_i ? {1'b0, W_INIT} : {1'b0, r_weight};
    for (int i = 0; i < W; i++) begin
      if (MSB_FIRST) begin
        w_rem_acc = {w_rem_acc[RW-1:0], x_i[W-1-i]};
        if (w_rem_acc >= N_EXT) w_rem_acc = w_rem_acc - N_EXT;
      end else begin
        if (x_i[i]) w_rem_acc = w_rem_acc + w_weight_acc;
        if (w_rem_acc >= N_EXT) w_rem_acc = w_rem_acc - N_EXT;
        w_weight_acc = {w_weight_acc[RW-1:0], 1'b0};
        if (w_weight_acc >= N_EXT) w_weight_acc = w_weight_acc - N_EXT;
      end
    end
  end

  always_comb begin
    w_len_sum = (clear_i ? '0 : {1'b0, r_len}) + W_STEP;
    w_len_nxt = w_len_sum[LEN_W] ? LEN_MAX : w_len_sum[LEN_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rem    <= '0;
      r_weight <= W_INIT;
      r_len    <= '0;
      r_div    <= 1'b1;
    end else if (valid_i) begin
      r_rem    <= w_rem_acc[RW-1:0];
      r_weight <= w_weight_acc[RW-1:0];
      r_len    <= w_len_nxt;
      r_div    <= (w_rem_acc == '0);
    end else if (clear_i) begin
      r_rem    <= '0;
      r_weight <= W_INIT;
      r_len    <= '0;
      r_div    <= 1'b1;
    end
  end

  assign div_o = r_div;
  assign rem_o = r_rem;
  assign len_o = r_len;

endmodule

// File: tb/tb_divisible_by_n_stream.sv
// tb/tb_divisible_by_n_stream.sv - randomized bench against a wide-integer golden value
// Each instance's number is rebuilt as a 256-bit integer and reduced with the % operator.

module tb_divisible_by_n_stream;

  localparam int NI = 7;
  localparam int N_A[NI] = '{3, 7, 5, 13, 1, 255, 200};
  localparam int W_A[NI] = '{1, 4, 1, 4, 3, 8, 8};
  localparam int M_A[NI] = '{1, 1, 0, 0, 1, 0, 1};
  localparam int L_A[NI] = '{16, 16, 16, 4, 16, 16, 8};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic       vld[NI];
  logic       clr[NI];
  logic [7:0] xin[NI];
  logic       dv[NI];
  int         rem_a[NI];
  int         len_a[NI];

  logic [255:0] gval[NI];
  int           gbits[NI];
  int           nchk = 0;
  int           nerr = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int GRW = (N_A[g] <= 2) ? 1 : $clog2(N_A[g]);
    logic [GRW-1:0]    rem_w;
    logic [L_A[g]-1:0] len_w;
    logic              dv_w;
    divisible_by_n_stream #(
      .DIVISOR(N_A[g]), .W(W_A[g]), .MSB_FIRST(M_A[g] != 0), .LEN_W(L_A[g])
    ) u_dut (
      .clk(clk), .reset(rst_n), .valid_i(vld[g]), .clear_i(clr[g]),
      .x_i(xin[g][W_A[g]-1:0]), .div_o(dv_w), .rem_o(rem_w), .len_o(len_w)
    );
    assign dv[g]    = dv_w;
    assign rem_a[g] = int'(rem_w);
    assign len_a[g] = int'(len_w);
  end

  task automatic check(input string tag, input int got, input int exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int g = 0; g < NI; g++) begin
      gval[g]  = '0;
      gbits[g] = 0;
    end
  endtask

  task automatic model_edge();
    for (int g = 0; g < NI; g++) begin
      logic [255:0] d;
      d = 256'(xin[g]) & ((256'(1) << W_A[g]) - 256'(1));
      if (clr[g]) begin
        gval[g]  = '0;
        gbits[g] = 0;
      end
      if (vld[g]) begin
        if (M_A[g] != 0) gval[g] = (gval[g] << W_A[g]) | d;
        else             gval[g] = gval[g] | (d << gbits[g]);
        gbits[g] += W_A[g];
      end
    end
  endtask

  task automatic check_all(input string ctx);
    for (int g = 0; g < NI; g++) begin
      int exp_rem;
      int exp_len;
      int max_len;
      exp_rem = int'(gval[g] % 256'(N_A[g]));
      max_len = (1 << L_A[g]) - 1;
      exp_len = (gbits[g] > max_len) ? max_len : gbits[g];
      check($sformatf("%s u%0d rem", ctx, g), rem_a[g], exp_rem);
      check($sformatf("%s u%0d div", ctx, g), int'(dv[g]), int'(exp_rem == 0));
      check($sformatf("%s u%0d len", ctx, g), len_a[g], exp_len);
    end
  endtask

  task automatic idle_all();
    for (int g = 0; g < NI; g++) begin
      vld[g] = 1'b0;
      clr[g] = 1'b0;
      xin[g] = 8'h00;
    end
  endtask

  task automatic step(input string ctx);
    model_edge();
    @(posedge clk);
    #1;
    check_all(ctx);
  endtask

  initial begin
    int b0[4] = '{1, 1, 0, 1};
    int r0[4] = '{1, 0, 0, 1};
    int b2[3] = '{1, 0, 1};
    int r2[3] = '{1, 1, 0};

    idle_all();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      idle_all();
      vld[0] = 1'b1;
      xin[0] = 8'(b0[i]);
      step("n3 msb");
      check("n3 rem plan", rem_a[0], r0[i]);
      check("n3 len plan", len_a[0], i + 1);
    end

    idle_all();
    vld[1] = 1'b1;
    xin[1] = 8'h1;
    step("n7 d1");
    check("n7 rem after 0x1", rem_a[1], 1);
    for (int i = 0; i < 2; i++) begin
      idle_all();
      xin[1] = 'x;
      step("n7 gap");
      check("n7 rem hold", rem_a[1], 1);
      check("n7 len hold", len_a[1], 4);
    end
    idle_all();
    vld[1] = 1'b1;
    xin[1] = 8'h5;
    step("n7 d2");
    check("n7 rem 21", rem_a[1], 0);
    check("n7 div 21", int'(dv[1]), 1);
    check("n7 len 21", len_a[1], 8);

    for (int i = 0; i < 3; i++) begin
      idle_all();
      vld[2] = 1'b1;
      xin[2] = 8'(b2[i]);
      step("n5 lsb");
      check("n5 rem plan", rem_a[2], r2[i]);
    end

    idle_all();
    clr[1] = 1'b1;
    vld[1] = 1'b1;
    xin[1] = 8'h3;
    step("n7 restart");
    check("n7 restart rem", rem_a[1], 3);
    check("n7 restart len", len_a[1], 4);

    idle_all();
    clr[1] = 1'b1;
    step("n7 clear");
    check("n7 clear rem", rem_a[1], 0);
    check("n7 clear div", int'(dv[1]), 1);
    check("n7 clear len", len_a[1], 0);

    for (int i = 0; i < 5; i++) begin
      idle_all();
      vld[3] = 1'b1;
      xin[3] = 8'($urandom);
      step("n13 sat");
      check("n13 len sat", len_a[3], (4 * (i + 1) > 15) ? 15 : 4 * (i + 1));
    end

    for (int i = 0; i < 3; i++) begin
      for (int g = 0; g < NI; g++) begin
        vld[g] = 1'b1;
        clr[g] = 1'b0;
        xin[g] = 8'($urandom);
      end
      step("pre reset");
    end
    idle_all();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async reset");
    check("async reset div n7", int'(dv[1]), 1);
    rst_n = 1'b1;

    for (int c = 0; c < 160; c++) begin
      for (int g = 0; g < NI; g++) begin
        clr[g] = (gbits[g] + W_A[g] > 256) || ($urandom_range(0, 19) == 0);
        vld[g] = ($urandom_range(0, 3) != 0);
        xin[g] = 8'($urandom);
      end
      step("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
